// File: rtl/pat_mem_arbiter.sv
// pat_mem_arbiter
//   Arbitrates a single-port pattern memory between the pixel-fetch read path
//   and the host read/write path. Fetch has priority; a starvation counter
//   force-grants the host for one cycle after STARVE_MAX consecutive denials.
//   Grants are combinational. The granted access is registered onto the
//   memory port one cycle later. Read data returns one cycle after mem_rd and
//   is steered to its owner by a 2-entry tag pipeline.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   fetch_req/addr -> fetch_gnt       pixel-fetch read request / grant
//   fetch_rvalid, fetch_rdata         fetch read return (rdata zero when idle)
//   host_req/we/addr/wdata/be         host access request
//   host_gnt, host_rvalid, host_rdata host grant / read return
//   mem_cs/rd/wr/addr/be/wdata        registered memory command
//   mem_rdata                         memory read data (1-cycle latency)
module pat_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 256,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_gnt,
  output logic                fetch_rvalid,
  output logic [DATA_W-1:0]   fetch_rdata,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic [DATA_W/8-1:0] host_be,
  output logic                host_gnt,
  output logic                host_rvalid,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                mem_cs,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  // Owner pipeline: entry 0 tracks the read on the memory port this cycle,
  // entry 1 tracks the read whose data is on mem_rdata this cycle.
  logic [1:0]        rd_vld_q, rd_vld_d;
  logic [1:0]        rd_host_q, rd_host_d;

  logic force_host;
  logic fetch_gnt_c, host_gnt_c;

  // Grant logic. The host wins over fetch only on the single cycle where the
  // counter has saturated; granting clears the counter, so the override
  // lasts exactly one cycle.
  always_comb begin
    force_host  = host_req && (starve_q == CNT_MAX);
    host_gnt_c  = 1'b0;
    fetch_gnt_c = 1'b0;
    if (rst_n) begin
      host_gnt_c  = host_req && (!fetch_req || force_host);
      fetch_gnt_c = fetch_req && !host_gnt_c;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (host_gnt_c) begin
      starve_d = '0;
    end else if (host_req && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Memory command register. Address, byte enables and write data hold
  // their last values when nothing is granted; only the strobes drop.
  always_comb begin
    mem_cs_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if (fetch_gnt_c) begin
      mem_cs_d    = 1'b1;
      mem_rd_d    = 1'b1;
      mem_addr_d  = fetch_addr;
      mem_be_d    = {BE_W{1'b1}};
      mem_wdata_d = '0;
    end else if (host_gnt_c) begin
      mem_cs_d    = 1'b1;
      mem_rd_d    = !host_we;
      mem_wr_d    = host_we;
      mem_addr_d  = host_addr;
      mem_be_d    = host_be;
      mem_wdata_d = host_wdata;
    end
  end

  always_comb begin
    rd_vld_d     = '0;
    rd_host_d    = '0;
    rd_vld_d[0]  = fetch_gnt_c || (host_gnt_c && !host_we);
    rd_host_d[0] = host_gnt_c;
    rd_vld_d[1]  = rd_vld_q[0];
    rd_host_d[1] = rd_host_q[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      mem_cs_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_vld_q    <= '0;
      rd_host_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_cs_q    <= mem_cs_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= rd_vld_d;
      rd_host_q   <= rd_host_d;
    end
  end

  // Outputs are forced to zero for the whole reset-low cycle, not just
  // after the first reset edge, so nothing escapes while rst_n is low.
  always_comb begin
    fetch_gnt    = fetch_gnt_c;
    host_gnt     = host_gnt_c;
    fetch_rvalid = rst_n && rd_vld_q[1] && !rd_host_q[1];
    host_rvalid  = rst_n && rd_vld_q[1] && rd_host_q[1];
    fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    host_rdata   = host_rvalid ? mem_rdata : '0;
    mem_cs       = rst_n && mem_cs_q;
    mem_rd       = rst_n && mem_rd_q;
    mem_wr       = rst_n && mem_wr_q;
    mem_addr     = rst_n ? mem_addr_q  : '0;
    mem_be       = rst_n ? mem_be_q    : '0;
    mem_wdata    = rst_n ? mem_wdata_q : '0;
  end

endmodule

// File: tb/tb_pat_mem_arbiter.sv
module tb_pat_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 256;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [BW-1:0] host_be = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_cs, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  pat_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, word content = address + 0x100.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= DW'(mem_addr) + DW'('h100);
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit            host;
    logic [DW-1:0] data;
    int            cyc;
  } rd_exp_t;
  rd_exp_t sb[$];

  // Expected memory-port state for the current cycle.
  logic          e_cs = 0, e_rd = 0, e_wr = 0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_be = '0;
  logic [DW-1:0] e_wd = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic fr, input logic [AW-1:0] fa,
                      input logic hr, input logic hw, input logic [AW-1:0] ha,
                      input logic [DW-1:0] hd, input logic [BW-1:0] hbe,
                      input logic efg, input logic ehg);
    rd_exp_t e;
    @(posedge clk); #1;
    rst_n = r; fetch_req = fr; fetch_addr = fa;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_be = hbe;
    @(negedge clk);
    if (!r) begin
      e_cs = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0;
    end
    chk("fetch_gnt", DW'(fetch_gnt), DW'(efg));
    chk("host_gnt",  DW'(host_gnt),  DW'(ehg));
    chk("mem_cs",    DW'(mem_cs),    DW'(e_cs));
    chk("mem_rd",    DW'(mem_rd),    DW'(e_rd));
    chk("mem_wr",    DW'(mem_wr),    DW'(e_wr));
    chk("mem_addr",  DW'(mem_addr),  DW'(e_addr));
    chk("mem_be",    DW'(mem_be),    DW'(e_be));
    chk("mem_wdata", mem_wdata,      e_wd);
    e_cs = 0; e_rd = 0; e_wr = 0;
    if (r && efg) begin
      e_cs = 1; e_rd = 1; e_addr = fa; e_be = '1; e_wd = '0;
      e.host = 0; e.data = DW'(fa) + DW'('h100); e.cyc = cyc + 2;
      sb.push_back(e);
    end else if (r && ehg) begin
      e_cs = 1; e_rd = !hw; e_wr = hw; e_addr = ha; e_be = hbe; e_wd = hd;
      if (!hw) begin
        e.host = 1; e.data = DW'(ha) + DW'('h100); e.cyc = cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever a read return is presented.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (fetch_rvalid && host_rvalid) begin
        n_err++;
        $display("FAIL both_rvalid at cycle %0d: got both high expected at most one", cyc);
      end
      if (fetch_rvalid || host_rvalid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rvalid at cycle %0d: fetch=%0b host=%0b expected none", cyc, fetch_rvalid, host_rvalid);
        end else begin
          e = sb.pop_front();
          chk("rvalid_owner", DW'(host_rvalid), DW'(e.host));
          chk("rdata", e.host ? host_rdata : fetch_rdata, e.data);
          chk("rvalid_cycle", DW'(cyc), DW'(e.cyc));
        end
      end
      if (!fetch_rvalid) chk("fetch_rdata_idle", fetch_rdata, '0);
      if (!host_rvalid)  chk("host_rdata_idle",  host_rdata,  '0);
    end
  end

  initial begin
    // Reset with both requesters asserted: no grants, everything zero.
    for (int i = 0; i < 3; i++) step(0, 1, 11'h3, 1, 0, 11'h4, '0, '1, 0, 0);
    idle(2);

    // Fetch-only reads at addresses 0,1,2 back to back.
    for (int i = 0; i < 3; i++) step(1, 1, AW'(i), 0, 0, '0, '0, '0, 1, 0);
    idle(3);

    // Host write to the top address with fetch idle.
    step(1, 0, '0, 1, 1, 11'h7FF, DW'('h77), '1, 0, 1);
    idle(3);

    // Both requesting continuously: 8 fetch grants then 1 host grant.
    for (int k = 0; k < 27; k++) begin
      if (k % 9 == 8) step(1, 1, 11'h3, 1, 0, 11'h4, '0, '1, 0, 1);
      else            step(1, 1, 11'h3, 1, 0, 11'h4, '0, '1, 1, 0);
    end
    idle(3);

    // Alternating fetch read addr 5 and host read addr 9.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) step(1, 1, 11'h5, 0, 0, '0, '0, '0, 1, 0);
      else            step(1, 0, '0, 1, 0, 11'h9, DW'('h55), 32'h0000FFFF, 0, 1);
    end
    idle(3);

    // Host read killed by a one-cycle reset while on the memory port.
    step(1, 0, '0, 1, 0, 11'h9, '0, '1, 0, 1);
    void'(sb.pop_back());
    step(0, 0, '0, 0, 0, '0, '0, '0, 0, 0);
    idle(2);
    step(1, 1, 11'h2, 0, 0, '0, '0, '0, 1, 0);
    step(1, 0, '0, 1, 0, 11'h6, '0, '1, 0, 1);
    idle(1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d reads outstanding expected 0", sb.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pat_mem_arbiter.md
PAT_MEM_ARBITER -- requirements
Module: pat_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the pattern memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 256, meaning the memory word width; byte-enable width is DATA_W/8.
REQ-003 The block SHALL have parameter STARVE_MAX, default 8, meaning consecutive denied host-request cycles before the host is force-granted.
REQ-004 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 The block SHALL have port fetch_req, input, 1, pixel-fetch read request, held until granted.
REQ-007 The block SHALL have port fetch_addr, input, ADDR_W, fetch read address, stable while fetch_req is high.
REQ-008 The block SHALL have ports fetch_gnt, output, 1, grant; fetch_rvalid, output, 1, read data valid; fetch_rdata, output, DATA_W, read data.
REQ-009 The block SHALL have ports host_req, input, 1, host access request; host_we, input, 1, 1=write 0=read; host_addr, input, ADDR_W; host_wdata, input, DATA_W; host_be, input, DATA_W/8.
REQ-010 The block SHALL have ports host_gnt, output, 1; host_rvalid, output, 1; host_rdata, output, DATA_W.
REQ-011 The block SHALL have memory-side ports mem_cs, mem_rd, mem_wr, output, 1; mem_addr, output, ADDR_W; mem_be, output, DATA_W/8; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W.

Function
REQ-012 Grant SHALL be combinational in the request cycle; at most one of fetch_gnt, host_gnt high per cycle.
REQ-013 Default priority: fetch over host; host granted only when fetch_req is low.
REQ-014 Starvation counter: increments each cycle host_req is high and host_gnt is low; clears on host_gnt; saturates at STARVE_MAX.
REQ-015 When the counter equals STARVE_MAX and host_req is high, host SHALL be granted over fetch_req for exactly that one cycle.
REQ-016 A granted access SHALL be registered onto the memory port in the cycle after grant: mem_cs=1, mem_rd or mem_wr per access type, mem_addr/mem_be/mem_wdata from the granted requester.
REQ-017 Fetch reads SHALL drive mem_be all ones and mem_wdata zero; host writes drive host_be and host_wdata.
REQ-018 With no grant in the previous cycle, mem_cs, mem_rd, mem_wr SHALL be 0 and address/data hold their last values.
REQ-019 Memory read latency is 1: the cycle after mem_rd=1, the owning requester's rvalid SHALL be 1 with rdata = mem_rdata; total grant-to-rvalid latency 2 cycles.
REQ-020 A 2-entry owner pipeline (fetch/host tag) SHALL route read data; back-to-back reads from alternating requesters return in issue order, one per cycle.
REQ-021 Host writes SHALL produce no host_rvalid.
REQ-022 fetch_rdata and host_rdata SHALL be zero when their rvalid is low.
REQ-023 Full throughput: continuous fetch_req with host idle SHALL yield one fetch grant per cycle.

Reset
REQ-024 While rst_n=0: all grants, rvalids, mem_cs, mem_rd, mem_wr, mem_addr, mem_be, mem_wdata, rdata outputs, starvation counter, and owner pipeline SHALL be 0.
REQ-025 Reset asserted mid-read SHALL discard the in-flight read; no rvalid in the cycle following reset release.

Verification
REQ-026 Fetch only, addresses 0,1,2 on consecutive cycles, mem_rdata = addr+0x100 -> fetch_rvalid on cycles 2,3,4 with data 0x100,0x101,0x102.
REQ-027 Host write addr 0x7FF, be 0xFFFFFFFF, data 0x77 with fetch idle -> next cycle mem_wr=1, mem_addr=0x7FF, mem_wdata=0x77; no host_rvalid.
REQ-028 fetch_req and host_req both high continuously -> fetch granted 8 cycles, host granted on 9th, counter back to 0, pattern repeats every 9 cycles.
REQ-029 Alternating fetch read addr 5 and host read addr 9 -> rvalids alternate fetch/host with data for addr 5 and addr 9 respectively, never both in a cycle.
REQ-030 rst_n low for 1 cycle while a host read is in flight -> host_rvalid stays 0, all memory strobes 0 next cycle, normal grants resume after.
